// File: rtl/rc_pkg.sv
// Shared types and constants for the radio frame controller.
// Channel data width, FSM state encoding and CPU status word layout.
package rc_pkg;

  localparam int PW_W          = 12;
  localparam int ST_STATE_LSB  = 0;
  localparam int ST_STATE_W    = 2;
  localparam int ST_ONLINE_LSB = 2;

  typedef enum logic [1:0] {
    NOSIG  = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    FS     = 2'd3
  } rc_state_t;

endpackage

// File: rtl/rc_frame_ctrl_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks.
module tick_gen #(
  parameter int DIV = 50
) (
  input  logic CLK,
  input  logic RESET_N,
  output logic EN_OUT
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (count == CW'(DIV - 1)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign EN_OUT = (count == CW'(DIV - 1));

endmodule

// File: rtl/rc_frame_ctrl.sv
// Frame gatherer, lock/failsafe FSM and CPU read port for a bank of
// pulse-width receivers.
module rc_frame_ctrl
  import rc_pkg::*;
#(
  parameter int NCH         = 6,
  parameter int DIV         = 50,
  parameter int PW_MIN      = 900,
  parameter int PW_MAX      = 2100,
  parameter int FS_PW       = 1000,
  parameter int LOCK_FRAMES = 4,
  parameter int FS_TIMEOUT  = 25000
) (
  input  logic                CLK,
  input  logic                RESET_N,
  output logic                EN,
  input  logic [NCH-1:0]      RX_ONLINE,
  input  logic [PW_W*NCH-1:0] RX_PW,
  input  logic [NCH-1:0]      RX_UPD,
  output logic                FRAME_VALID,
  output logic [1:0]          STATE,
  output logic                FAILSAFE,
  input  logic [3:0]          CH_SEL,
  output logic [PW_W-1:0]     CH_DATA
);

  localparam int TW   = $clog2(FS_TIMEOUT + 1);
  localparam int CNTW = $clog2(LOCK_FRAMES + 1);

  logic            en;
  logic [PW_W-1:0] pw [NCH];
  logic [NCH-1:0]  rng_bad;
  logic            upd_bad;
  logic [NCH-1:0]  mask;
  logic            bad_q;
  logic [PW_W-1:0] shadow [NCH];
  logic            complete, good, bad_frame;
  logic [TW-1:0]   timer;
  logic            timeout, offline;

  rc_state_t       state_q, state_d;
  logic [CNTW-1:0] good_cnt, cnt_d, cnt_inc;
  logic            load_snap, load_fs, fv_d;
  logic [PW_W-1:0] snapshot [NCH];
  logic            frame_valid;
  logic [PW_W-1:0] status, rd_data, ch_data;

  tick_gen #(.DIV(DIV)) u_tick (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .EN_OUT  (en)
  );

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pw[i]      = RX_PW[PW_W*i +: PW_W];
      rng_bad[i] = (pw[i] < PW_W'(PW_MIN)) || (pw[i] > PW_W'(PW_MAX));
    end
  end

  assign upd_bad   = |(RX_UPD & rng_bad);
  assign complete  = &mask;
  assign good      = complete && !bad_q;
  assign bad_frame = complete && bad_q;
  assign offline   = ~&RX_ONLINE;

  // Updates landing in the completion cycle seed the next frame.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mask  <= '0;
      bad_q <= 1'b0;
      for (int i = 0; i < NCH; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (RX_UPD[i]) shadow[i] <= pw[i];
      end
      if (complete) begin
        mask  <= RX_UPD;
        bad_q <= upd_bad;
      end else begin
        mask  <= mask | RX_UPD;
        bad_q <= bad_q | upd_bad;
      end
    end
  end

  // Entering FS restarts the timer so NOSIG needs a fresh full timeout.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      timer <= '0;
    end else if (good || load_fs) begin
      timer <= '0;
    end else if (en && (timer != TW'(FS_TIMEOUT))) begin
      timer <= timer + TW'(1);
    end
  end

  assign timeout = (timer == TW'(FS_TIMEOUT));
  assign cnt_inc = (good_cnt == CNTW'(LOCK_FRAMES)) ? good_cnt : good_cnt + CNTW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = good_cnt;
    load_snap = 1'b0;
    load_fs   = 1'b0;
    fv_d      = 1'b0;
    case (state_q)
      NOSIG: begin
        if (good) begin
          state_d = ACQ;
          cnt_d   = CNTW'(1);
        end
      end
      ACQ, FS: begin
        if (timeout) begin
          state_d = NOSIG;
          cnt_d   = '0;
        end else if (good) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNTW'(LOCK_FRAMES)) begin
            state_d   = LOCKED;
            load_snap = 1'b1;
            fv_d      = 1'b1;
          end
        end else if (bad_frame) begin
          cnt_d = '0;
        end
      end
      LOCKED: begin
        if (timeout || offline) begin
          state_d = FS;
          cnt_d   = '0;
          load_fs = 1'b1;
        end else if (good) begin
          load_snap = 1'b1;
          fv_d      = 1'b1;
        end
      end
      default: state_d = NOSIG;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= NOSIG;
      good_cnt    <= '0;
      frame_valid <= 1'b0;
      for (int i = 0; i < NCH; i++) snapshot[i] <= PW_W'(FS_PW);
    end else begin
      state_q     <= state_d;
      good_cnt    <= cnt_d;
      frame_valid <= fv_d;
      for (int i = 0; i < NCH; i++) begin
        if (load_fs)        snapshot[i] <= PW_W'(FS_PW);
        else if (load_snap) snapshot[i] <= shadow[i];
      end
    end
  end

  // Selects beyond the channel count read back the status word.
  always_comb begin
    status = '0;
    status[ST_STATE_LSB +: ST_STATE_W] = state_q;
    status[ST_ONLINE_LSB +: NCH]       = RX_ONLINE;
    rd_data = status;
    for (int i = 0; i < NCH; i++) begin
      if (CH_SEL == 4'(i)) rd_data = snapshot[i];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) ch_data <= '0;
    else          ch_data <= rd_data;
  end

  assign EN          = en;
  assign FRAME_VALID = frame_valid;
  assign STATE       = state_q;
  assign FAILSAFE    = (state_q == NOSIG) || (state_q == FS);
  assign CH_DATA     = ch_data;

endmodule

// File: doc/rc_frame_ctrl.md
Name: rc_frame_ctrl

Overview:
Controller for a bank of NCH radio_rx pulse-width receivers.
- Generates their shared sample-enable tick.
- Gathers per-channel pulse widths into frames and validates them.
- Runs a lock/failsafe state machine and publishes a snapshot of channel values, plus a registered read port for the CPU.
- Sits between the radio_rx instances and the quad-control register interface.

Parameters:
NCH, 6, number of radio channels (1..10)
DIV, 50, CLK cycles per EN tick (50 MHz -> 1 us)
PW_MIN, 900, minimum valid pulse width in EN ticks
PW_MAX, 2100, maximum valid pulse width in EN ticks
FS_PW, 1000, value forced into every snapshot channel when not locked
LOCK_FRAMES, 4, consecutive good frames required to lock
FS_TIMEOUT, 25000, EN ticks without a good frame before timeout

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
EN  out  1  sample tick to all radio_rx instances; one CLK cycle every DIV cycles
RX_ONLINE  in  NCH  ONLINE outputs of the receivers
RX_PW  in  12*NCH  PULSE_WIDTH outputs, channel i at bits [12i+11:12i]
RX_UPD  in  NCH  one-cycle strobe per channel when its PULSE_WIDTH is updated
FRAME_VALID  out  1  one-cycle strobe when the snapshot takes a new good frame
STATE  out  2  FSM state (rc_pkg encoding)
FAILSAFE  out  1  high in NOSIG or FS
CH_SEL  in  4  CPU read select
CH_DATA  out  12  CPU read data, registered

Behaviour:
Reset (RESET_N low, async):
- EN=0, FRAME_VALID=0, STATE=NOSIG, FAILSAFE=1, CH_DATA=0.
- Snapshot = FS_PW on all channels; mask, bad flag, counters = 0.
- Reset asserted mid-frame or mid-lock discards everything and returns to this state.

Prescaler:
- Counts 0..DIV-1; EN=1 exactly when count==DIV-1, then wraps to 0.

Frame accumulation:
- On RX_UPD[i]: shadow[i]<=RX_PW slice i; mask[i]<=1.
- If the sampled width is <PW_MIN or >PW_MAX, set the bad flag.
- Frame completes in the cycle mask==all ones.
  - Commit decision uses the registered shadow and bad flag.
  - mask is reloaded with this cycle's RX_UPD bits; bad is reloaded with their range result. Simultaneous updates therefore belong to the next frame.
- Repeated RX_UPD on a channel before frame completion overwrites shadow[i] and accumulates into the bad flag.

Timeout timer:
- Counts EN ticks; saturates at FS_TIMEOUT.
- Cleared on a good frame completion.
- timeout = (count==FS_TIMEOUT).

FSM (good = complete and not bad):
- NOSIG
  - good -> ACQ, good_cnt=1.
- ACQ
  - good: good_cnt++; when good_cnt reaches LOCK_FRAMES -> LOCKED, with snapshot<=shadow and FRAME_VALID.
  - bad frame: good_cnt=0.
  - timeout: -> NOSIG.
- LOCKED
  - good: snapshot<=shadow, FRAME_VALID=1.
  - bad frame: ignored; snapshot held; no strobe.
  - timeout or any RX_ONLINE bit low -> FS; snapshot<=FS_PW on the entry cycle.
- FS
  - Same counting as ACQ; LOCK_FRAMES consecutive good -> LOCKED.
  - timeout: -> NOSIG.
- Priority within a cycle: timeout/offline exit beats good-frame commit.
- FAILSAFE = (STATE==NOSIG || STATE==FS).
- good_cnt saturates at LOCK_FRAMES.

CPU read:
- CH_DATA is registered with 1-cycle latency.
- CH_SEL<NCH returns snapshot[CH_SEL].
- CH_SEL>=NCH returns a status word: [1:0]=STATE, [NCH+1:2]=RX_ONLINE, remaining bits 0.

Decomposition:
- rc_pkg holds:
  - state enum: NOSIG=2'd0, ACQ=2'd1, LOCKED=2'd2, FS=2'd3
  - PW_W=12
  - the status word field offsets
- Sub-module tick_gen(CLK, RESET_N, EN_OUT) parameterised by DIV, instantiated once.

Test Plan:
1. Reset, then run 200 cycles -> EN high at cycles 49, 99, 149, 199; STATE=0; FAILSAFE=1; every CH_SEL<6 reads 1000.
2. Send 4 frames, all 6 channels at width 1500 -> STATE goes 0->1 after frame 1 and 1->2 at frame 4, with one FRAME_VALID there; CH_SEL=2 reads 1500 one cycle later.
3. While LOCKED, send a frame with ch3=2500 -> no FRAME_VALID, snapshot unchanged, STATE=2. Next good frame at 1200 -> FRAME_VALID and snapshot=1200.
4. While LOCKED, drop RX_ONLINE[1] -> next cycle STATE=3, FAILSAFE=1, all channels 1000. Then 4 good frames -> STATE=2.
5. While LOCKED, send no updates for 25000 EN ticks -> STATE=3. Another 25000 ticks -> STATE=0.
6. Completion cycle coincides with RX_UPD[0] -> frame commits without that sample; mask restarts with bit 0 set; next frame needs only 5 more strobes. Also assert RESET_N low mid-frame -> all outputs return to reset values immediately.
